// File: rtl/mure_pkg.sv
// Shared types and widths for the trace-encoder front end: uop FIFO entries,
// exception info, the instruction-block record and the block-builder FSM states.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int ITYPE_LEN   = 3;
  localparam int PRIV_LEN    = 2;
  localparam int IRETIRE_LEN = 5;
  localparam int CAUSE_LEN   = 6;

  // Largest count an open block may hold and still absorb one more 32-bit uop.
  localparam logic [IRETIRE_LEN-1:0] MAX_OPEN_COUNT = IRETIRE_LEN'((1 << IRETIRE_LEN) - 3);

  typedef enum logic [ITYPE_LEN-1:0] {
    STD  = 3'd0,
    EXC  = 3'd1,
    INT  = 3'd2,
    ERET = 3'd3,
    NTB  = 3'd4,
    TB   = 3'd5
  } itype_e;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    itype_e              itype;
    logic                compressed;
    logic [PRIV_LEN-1:0] priv;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } exc_info_s;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    itype_e                 itype;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } te_block_s;

  // Uop size in halfwords: compressed uops are one halfword, the rest two.
  function automatic logic [IRETIRE_LEN-1:0] uop_size(input logic compressed);
    uop_size = compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  endfunction

  // Assemble a block record; exception fields only survive for EXC/INT closes.
  function automatic te_block_s make_block(input logic [XLEN-1:0]        iaddr,
                                           input logic [IRETIRE_LEN-1:0] iretire,
                                           input logic                   ilastsize,
                                           input itype_e                 itype,
                                           input logic [PRIV_LEN-1:0]    priv,
                                           input exc_info_s              exc);
    te_block_s blk;
    blk.iaddr     = iaddr;
    blk.iretire   = iretire;
    blk.ilastsize = ilastsize;
    blk.itype     = itype;
    blk.priv      = priv;
    blk.cause     = '0;
    blk.tval      = '0;
    if (itype == EXC || itype == INT) begin
      blk.cause = exc.cause;
      blk.tval  = exc.tval;
    end
    make_block = blk;
  endfunction

endpackage

// File: rtl/te_block_builder.sv
// Groups retired uops into instruction blocks. A block opens on a STD uop,
// grows while STD uops of the same privilege arrive, and closes on the first
// non-STD uop, on a privilege change, or before the halfword count could
// overflow. Closed blocks sit in a single output register slot.
//
// Handshakes: a uop transfers on a rising edge where uop_entry_i.valid and
// uop_ready_o are both high; a block transfers on a rising edge where
// blk_valid_o and blk_ready_i are both high. blk_* hold steady while
// blk_valid_o is high and blk_ready_i is low, and the slot may be refilled
// in the same edge it drains.
module te_block_builder
  import mure_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  uop_entry_s             uop_entry_i,
  input  exc_info_s              exc_info_i,
  output logic                   uop_ready_o,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [XLEN-1:0]        blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0] blk_iretire_o,
  output logic                   blk_ilastsize_o,
  output logic [ITYPE_LEN-1:0]   blk_itype_o,
  output logic [PRIV_LEN-1:0]    blk_priv_o,
  output logic [CAUSE_LEN-1:0]   blk_cause_o,
  output logic [XLEN-1:0]        blk_tval_o,
  output logic                   state_o
);

  state_e                 state_q;
  logic [IRETIRE_LEN-1:0] count_q;
  logic [XLEN-1:0]        open_iaddr_q;
  logic [PRIV_LEN-1:0]    open_priv_q;
  logic                   last_compressed_q;
  te_block_s              slot_q;
  logic                   slot_valid_q;

  logic                   slot_free;
  logic                   force_close;
  logic                   accept;
  logic [IRETIRE_LEN-1:0] size;
  exc_info_s              no_exc;

  // Close the open block early when the incoming uop cannot join it.
  always_comb begin
    slot_free   = !slot_valid_q || blk_ready_i;
    force_close = (state_q == COUNT) && uop_entry_i.valid && slot_free &&
                  ((uop_entry_i.priv != open_priv_q) || (count_q > MAX_OPEN_COUNT));
    uop_ready_o = slot_free && !force_close;
    accept      = uop_entry_i.valid && uop_ready_o;
    size        = uop_size(uop_entry_i.compressed);
    no_exc      = '0;
  end

  // Block FSM, halfword counter and output slot, all updated together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      count_q           <= '0;
      open_iaddr_q      <= '0;
      open_priv_q       <= '0;
      last_compressed_q <= 1'b0;
      slot_q            <= '0;
      slot_valid_q      <= 1'b0;
    end else begin
      // Drain first; a close below in the same edge overrides it.
      if (slot_valid_q && blk_ready_i) begin
        slot_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (uop_entry_i.itype == STD) begin
              open_iaddr_q      <= uop_entry_i.pc;
              open_priv_q       <= uop_entry_i.priv;
              count_q           <= size;
              last_compressed_q <= uop_entry_i.compressed;
              state_q           <= COUNT;
            end else begin
              slot_q       <= make_block(uop_entry_i.pc, size, !uop_entry_i.compressed,
                                         uop_entry_i.itype, uop_entry_i.priv, exc_info_i);
              slot_valid_q <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (force_close) begin
            slot_q       <= make_block(open_iaddr_q, count_q, !last_compressed_q,
                                       STD, open_priv_q, no_exc);
            slot_valid_q <= 1'b1;
            count_q      <= '0;
            state_q      <= IDLE;
          end else if (accept) begin
            if (uop_entry_i.itype == STD) begin
              count_q           <= count_q + size;
              last_compressed_q <= uop_entry_i.compressed;
            end else begin
              slot_q       <= make_block(open_iaddr_q, count_q + size, !uop_entry_i.compressed,
                                         uop_entry_i.itype, open_priv_q, exc_info_i);
              slot_valid_q <= 1'b1;
              count_q      <= '0;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_valid_o     = slot_valid_q;
  assign blk_iaddr_o     = slot_q.iaddr;
  assign blk_iretire_o   = slot_q.iretire;
  assign blk_ilastsize_o = slot_q.ilastsize;
  assign blk_itype_o     = slot_q.itype;
  assign blk_priv_o      = slot_q.priv;
  assign blk_cause_o     = slot_q.cause;
  assign blk_tval_o      = slot_q.tval;
  assign state_o         = state_q;

endmodule

// File: doc/te_block_builder.md
TE_BLOCK_BUILDER -- requirements
Module: te_block_builder

Interface
REQ-001 Parameters: none; all widths from mure_pkg (XLEN, ITYPE_LEN, PRIV_LEN, IRETIRE_LEN, CAUSE_LEN).
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 uop_entry_i  in  uop_entry_s  retired uop from the uop FIFO; .valid is the request.
REQ-005 exc_info_i  in  exc_info_s  cause/tval; meaningful only with an EXC/INT uop.
REQ-006 uop_ready_o  out  1  uop consumed this cycle when high with .valid.
REQ-007 blk_valid_o  out  1  a closed instruction block is presented.
REQ-008 blk_ready_i  in  1  downstream packet encoder accepts the block.
REQ-009 blk_iaddr_o  out  XLEN  pc of first uop in block.
REQ-010 blk_iretire_o  out  IRETIRE_LEN  block size in 16-bit halfwords.
REQ-011 blk_ilastsize_o  out  1  last uop size: 0 = 16-bit, 1 = 32-bit.
REQ-012 blk_itype_o  out  ITYPE_LEN  itype_e of the closing uop, STD for forced close.
REQ-013 blk_priv_o  out  PRIV_LEN  privilege of the block.
REQ-014 blk_cause_o / blk_tval_o  out  CAUSE_LEN / XLEN  exc info, zero unless itype EXC or INT.

Function
REQ-015 Handshake: transfer on uop when .valid && uop_ready_o; on block when blk_valid_o && blk_ready_i.
REQ-016 Output is a single register slot; blk_* are stable while blk_valid_o && !blk_ready_i.
REQ-017 slot_free = !blk_valid_o || blk_ready_i; uop_ready_o = slot_free && !force_close.
REQ-018 Uop size: compressed -> 1 halfword, else 2.
REQ-019 FSM uses state_e: IDLE (no open block), COUNT (open block).
REQ-020 IDLE, accepted uop, itype == STD: iaddr <= pc, count <= size, priv latched, -> COUNT.
REQ-021 IDLE, accepted uop, itype != STD: single-uop block written to slot next edge, stay IDLE.
REQ-022 COUNT, accepted STD uop: count += size, last_compressed updated, stay COUNT.
REQ-023 COUNT, accepted non-STD uop: block closed with count+size, that itype, ilastsize = !compressed, -> IDLE.
REQ-024 force_close (COUNT && .valid && slot_free && (uop priv != block priv || count > 2^IRETIRE_LEN-1-2)).
REQ-025 On force_close: uop not accepted; block emitted with itype STD, ilastsize = !last_compressed; -> IDLE; uop accepted on a later cycle.
REQ-026 count never wraps; force_close guarantees count + 2 fits in IRETIRE_LEN bits.
REQ-027 EXC/INT closing uop: cause/tval sampled from exc_info_i in the accept cycle; else zeroed.
REQ-028 Latency: blk_valid_o high the cycle after the closing accept/force_close edge.
REQ-029 Simultaneous drain and close: blk_ready_i high with a new close replaces the slot in the same edge, no bubble.
REQ-030 Slot full and not draining: uop_ready_o low and FSM holds; an open block is never lost.
REQ-031 Invalid uop (.valid low) changes nothing; an open block stays open indefinitely.

Reset
REQ-032 On rst_ni low, asynchronously: FSM = IDLE, count = 0, blk_valid_o = 0, all blk_* = 0.
REQ-033 uop_ready_o derives from reset state, so it is 1 after reset.
REQ-034 Reset mid-block discards the open block and the slot contents without emitting them.

Structure
REQ-035 Add te_block_s (iaddr, iretire, ilastsize, itype, priv, cause, tval) to mure_pkg; the slot holds one te_block_s.
REQ-036 Reuse itype_e, uop_entry_s, exc_info_s and state_e from mure_pkg; no new FSM enum.
REQ-037 No sub-module; FSM, counter and output slot are in one module of about 150-250 lines.

Verification
REQ-038 Uops pc 0x100 STD c=0, 0x104 STD c=1, 0x106 TB c=0, blk_ready_i = 1 -> one block: iaddr 0x100, iretire 5, ilastsize 1, itype TB.
REQ-039 IDLE, EXC uop pc 0x200 c=1, cause 2, tval 0xdead -> block: iaddr 0x200, iretire 1, ilastsize 0, itype EXC, cause 2, tval 0xdead.
REQ-040 Open block priv 3 with 2 STD uops; next uop priv 0 -> uop_ready_o low 1 cycle; STD block iretire 4 emitted; new block starts at that uop.
REQ-041 blk_ready_i = 0 while two blocks close -> first held stable, uop_ready_o low until drained; second emitted next, no loss.
REQ-042 Stream of 32-bit STD uops with no branch -> forced STD close when count reaches 2^IRETIRE_LEN-2; no wrap.
REQ-043 rst_ni low mid-COUNT with full slot -> all outputs 0 asynchronously; after release first block starts fresh.
